// File: rtl/load_store_unit_if.sv
// Data-bus bundle between the load/store unit and the memory fabric.
// Master drives the request (req/we/addr/wdata/be); slave answers with ack/rdata.
// Ports: bus_req, bus_we, bus_addr[31:0], bus_wdata[31:0], bus_be[3:0], bus_ack, bus_rdata[31:0].
interface load_store_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Purpose: single-outstanding load/store unit bridging the core to a req/ack data bus.
// Latency: 3 cycles minimum (IDLE, BUS, DONE); BUS lasts until ack or TIMEOUT wait cycles.
// Backpressure: stall holds the core while a request is pending; bus_req held until ack or timeout.
//
// Ports: clk, rst_n (async, active-low); mem_rd/mem_wr/funct3/addr/wdata from the core;
// load_data/stall back to the core; bus_err timeout pulse; bus = data-bus master modport.
// Option: define LSU_MISALIGN_TRAP_EN to add the misalign output and trap unaligned H/W
// accesses without touching the bus; otherwise the low address bits are ignored.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        bus_err,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  load_store_unit_if.master bus
);

  // Last BUS wait cycle before the timeout fires (counter counts 0..TIMEOUT-1).
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  // Request latched on IDLE exit so the core-side inputs may change freely afterwards.
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic [7:0]  r_cnt;
  logic [31:0] r_load_data;
  logic        r_bus_err;

  logic        w_req;
  logic        w_bus_req;
  logic        w_ack_hit;
  logic        w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdat;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;
  logic [31:0] w_fmt;

`ifdef LSU_MISALIGN_TRAP_EN
  logic        w_misal;
  logic        w_trap;
  logic        r_misalign;

  // funct3[1:0]==01 is a halfword; funct3[1]==1 covers W and every reserved code (treated as W).
  assign w_misal = ((funct3[1:0] == 2'b01) & addr[0]) | (funct3[1] & (|addr[1:0]));
`endif

  // A simultaneous load+store request is a store.
  assign w_req = mem_rd | mem_wr;

  // ---------------------------------------------------------------- FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------- FSM next state / outputs
  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    w_bus_req   = 1'b0;
    w_ack_hit   = 1'b0;
    w_timeout   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    w_trap      = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        stall = w_req;
        if (w_req) begin
`ifdef LSU_MISALIGN_TRAP_EN
          if (w_misal) begin
            w_trap      = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_BUS;
          end
`else
          w_state_nxt = S_BUS;
`endif
        end
      end
      S_BUS: begin
        stall     = 1'b1;
        w_bus_req = 1'b1;
        // Ack is checked first so an ack on the final wait cycle beats the timeout.
        if (bus.bus_ack) begin
          w_ack_hit   = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_cnt == LP_CNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- request latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if ((r_state == S_IDLE) && w_req) begin
      r_we    <= mem_wr;
      r_f3    <= funct3;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  // ---------------------------------------------------------------- bus wait counter
  // Held at zero outside BUS, which gives the clear-on-entry behaviour for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state != S_BUS) begin
      r_cnt <= '0;
    end else if (!bus.bus_ack) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------------- store lanes / byte enables
  always_comb begin
    case (r_f3[1:0])
      2'b00: begin
        w_be   = 4'b0001 << r_addr[1:0];
        w_wdat = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be   = 4'b0011 << {r_addr[1], 1'b0};
        w_wdat = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wdat = r_wdata;
      end
    endcase
    // Loads always fetch the whole word; lane selection happens on the way back.
    if (!r_we) begin
      w_be = 4'b1111;
    end
  end

  assign bus.bus_req   = w_bus_req;
  assign bus.bus_we    = w_bus_req & r_we;
  assign bus.bus_be    = w_bus_req ? w_be : 4'b0000;
  assign bus.bus_addr  = w_bus_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus.bus_wdata = w_bus_req ? w_wdat : 32'h0;

  // ---------------------------------------------------------------- load formatting
  assign w_sign = ~r_f3[2];

  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = bus.bus_rdata[7:0];
      2'd1:    w_byte = bus.bus_rdata[15:8];
      2'd2:    w_byte = bus.bus_rdata[23:16];
      default: w_byte = bus.bus_rdata[31:24];
    endcase
    w_half = r_addr[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    case (r_f3[1:0])
      2'b00:   w_fmt = {{24{w_sign & w_byte[7]}}, w_byte};
      2'b01:   w_fmt = {{16{w_sign & w_half[15]}}, w_half};
      default: w_fmt = bus.bus_rdata;
    endcase
  end

  // ---------------------------------------------------------------- result / status registers
  // load_data only changes on the edge into DONE, so it is valid in DONE and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_data <= '0;
    end else if (w_ack_hit && !r_we) begin
      r_load_data <= w_fmt;
    end else if (w_timeout) begin
      r_load_data <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
    end else if (w_trap) begin
      r_load_data <= '0;
`endif
    end
  end

  // Set on the edge into DONE; DONE lasts one cycle so this is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_trap;
    end
  end

  assign misalign = r_misalign;
`endif

  assign load_data = r_load_data;
  assign bus_err   = r_bus_err;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the number of bus-wait cycles before a transaction is aborted (legal range 1..255).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port mem_rd  input  1  load request from control; held by the core while stall=1.
REQ-005 SHALL have port mem_wr  input  1  store request from control; held by the core while stall=1.
REQ-006 SHALL have port funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port addr  input  32  byte address from the ALU.
REQ-008 SHALL have port wdata  input  32  store data (rs2).
REQ-009 SHALL have port load_data  output  32  formatted load result, the mem input of the result mux.
REQ-010 SHALL have port stall  output  1  freezes PC and register write-back while high.
REQ-011 SHALL have port bus_req, bus_we, bus_addr[31:0], bus_wdata[31:0] and bus_be[3:0], all outputs, forming the data-bus request.
REQ-012 SHALL have port bus_ack  input  1  and port bus_rdata  input  32, forming the bus response.
REQ-013 SHALL have port bus_err  output  1  one-cycle pulse on a timeout.

Function
REQ-014 SHALL implement three states: IDLE, BUS and DONE.
REQ-015 In IDLE with mem_rd or mem_wr high, the block SHALL latch the request and move to BUS on the next edge.
REQ-016 In IDLE the block SHALL drive stall = mem_rd | mem_wr combinationally.
REQ-017 In BUS the block SHALL hold stall=1 and bus_req=1.
REQ-018 In BUS, bus_addr SHALL be {addr[31:2],2'b00} and bus_we SHALL be 1 for stores.
REQ-019 Byte-enable rules: SB gives 4'b0001<<addr[1:0]; SH gives 4'b0011<<{addr[1],1'b0}; SW and all loads give 4'b1111.
REQ-020 Store data SHALL be replicated across lanes: SB uses {4{wdata[7:0]}}, SH uses {2{wdata[15:0]}}, SW uses wdata.
REQ-021 On bus_ack in BUS, the block SHALL capture bus_rdata, drop bus_req on the next edge and move to DONE.
REQ-022 The minimum access latency SHALL be 3 cycles (IDLE, BUS, DONE).
REQ-023 In DONE, stall SHALL be 0 and load_data SHALL be valid for exactly that cycle; the next state SHALL be IDLE.
REQ-024 Load formatting SHALL select the lane by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
REQ-025 Reserved funct3 codes SHALL be treated as W.
REQ-026 A cycle counter SHALL clear on BUS entry and increment each BUS cycle without ack.
REQ-027 When the counter reaches TIMEOUT, the block SHALL drop bus_req, pulse bus_err for 1 cycle, move to DONE and force load_data=0.
REQ-028 If ack arrives in the same cycle the counter reaches TIMEOUT, the ack SHALL win and no bus_err SHALL be raised.
REQ-029 When mem_rd and mem_wr are both high, the access SHALL be a store.
REQ-030 Outside DONE, load_data SHALL hold its last value.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, bus_req=0, bus_we=0, bus_be=0, bus_err=0, load_data=0 and counter=0.
REQ-032 A reset mid-BUS SHALL abandon the transaction with no DONE cycle.
REQ-033 In IDLE after reset, stall SHALL follow REQ-016.

Configuration
REQ-034 The macro LSU_MISALIGN_TRAP_EN SHALL control misalignment handling.
REQ-035 With LSU_MISALIGN_TRAP_EN defined, the block SHALL add output misalign (1 bit).
REQ-036 With LSU_MISALIGN_TRAP_EN defined, an H access with addr[0]=1 or a W access with addr[1:0]!=0 SHALL issue no bus request, go IDLE->DONE, pulse misalign for 1 cycle in DONE and force load_data=0.
REQ-037 Without LSU_MISALIGN_TRAP_EN, the misalign port SHALL be absent and addr[0] (H) or addr[1:0] (W) SHALL be ignored, with the access proceeding aligned.

Verification
REQ-038 LB with addr=0x1003, bus_rdata=0x80FF_1234 and ack in the first BUS cycle -> load_data=0xFFFF_FF80 in DONE; stall high for exactly 2 cycles.
REQ-039 SH with addr=0x2002 and wdata=0x0000_BEEF -> bus_be=4'b1100, bus_wdata=0xBEEF_BEEF, bus_we=1, bus_addr=0x2000.
REQ-040 LW with ack withheld -> bus_req high for TIMEOUT=16 cycles, then one bus_err pulse and load_data=0 in DONE.
REQ-041 Ack in the same cycle the counter reaches TIMEOUT -> data captured and bus_err stays 0.
REQ-042 rst_n low in the 2nd BUS cycle -> bus_req=0 immediately, state IDLE and no DONE pulse.
REQ-043 With LSU_MISALIGN_TRAP_EN, LW at addr=0x3001 -> bus_req never asserted, misalign pulses once and load_data=0; without the macro the same access reads 0x3000.
